// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the memory-mapped I/O port controller.
//   - Register word offsets within the 16-byte window.
//   - STATUS and CTRL bit positions.
//   - TX state type and a small saturating helper for the STATUS count field.
package io_pkg;

    localparam logic [3:0] RXDATA_OFS = 4'd0;
    localparam logic [3:0] TXDATA_OFS = 4'd4;
    localparam logic [3:0] STATUS_OFS = 4'd8;
    localparam logic [3:0] CTRL_OFS   = 4'd12;

    // STATUS bit positions
    localparam int unsigned ST_NONEMPTY = 0;
    localparam int unsigned ST_FULL     = 1;
    localparam int unsigned ST_COUNT_LO = 2;  // 3-bit field [4:2]
    localparam int unsigned ST_TX_BUSY  = 5;
    localparam int unsigned ST_RX_EN    = 6;
    localparam int unsigned ST_TX_OVR   = 7;

    // CTRL bit positions
    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVR = 1;
    localparam int unsigned CTRL_RX_EN   = 2;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    // Clamp an occupancy count into the 3-bit STATUS field.
    function automatic logic [2:0] sat3(input int unsigned n);
        return (n > 7) ? 3'd7 : 3'(n);
    endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// io_port_ctrl_if: processor-bus and external RX/TX channel signals of io_port_ctrl.
//   master: processor / external environment side (drives address, strobes, RX byte, TX ack).
//   slave : the controller (drives Sel, RdData, in_ready, out_data, out_valid).
interface io_port_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [31:0]      Adr;
    logic [31:0]      WriteData;
    logic             MemWrite;
    logic             MemtoReg;
    logic             Sel;
    logic [31:0]      RdData;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ack;

    modport master (
        output Adr, WriteData, MemWrite, MemtoReg, in_data, in_valid, out_ack,
        input  Sel, RdData, in_ready, out_data, out_valid
    );

    modport slave (
        input  Adr, WriteData, MemWrite, MemtoReg, in_data, in_valid, out_ack,
        output Sel, RdData, in_ready, out_data, out_valid
    );
endinterface

// File: rtl/io_rx_fifo.sv
// io_rx_fifo: synchronous receive FIFO.
//   clk, resetE     : clock, synchronous active-low reset
//   push, wdata     : enqueue wdata (ignored when full)
//   pop             : dequeue head (ignored when empty)
//   flush           : empty the FIFO; wins over same-cycle push and pop
//   head            : entry at the read pointer (meaningless when empty)
//   count/full/empty: occupancy
module io_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetE,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // DEPTH is a power of two, so pointer overflow wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy tracking alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O controller with handshaked RX/TX byte channels.
//   clk, resetE : clock, synchronous active-low reset
//   bus (slave) : Adr/WriteData/MemWrite/MemtoReg from the core, Sel/RdData back to the
//                 ReadData mux; in_data/in_valid/in_ready RX channel;
//                 out_data/out_valid/out_ack TX channel.
// Window of four words at BASE: RXDATA, TXDATA, STATUS, CTRL. Reads are combinational.
module io_port_ctrl
    import io_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h800,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           resetE,
    io_port_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]      ofs_full;
    logic [3:0]       ofs;
    logic             sel;
    logic             rd_strobe, wr_strobe;
    logic             rx_pop, rx_push, rx_flush;
    logic             tx_wr, ctrl_wr, clr_ovr;
    logic [WIDTH-1:0] rx_head;
    logic [CW-1:0]    rx_count;
    logic             rx_full, rx_empty;
    logic [31:0]      status, rd_data;

    tx_state_t        tx_state_q, tx_state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             tx_ovr_q, tx_ovr_d;
    logic             rx_en_q, rx_en_d;

    // Subtracting BASE keeps the decode correct for any word-aligned base.
    assign ofs_full  = bus.Adr - BASE;
    assign sel       = (ofs_full < 32'd16);
    assign ofs       = {ofs_full[3:2], 2'b00};
    assign rd_strobe = sel & bus.MemtoReg;
    assign wr_strobe = sel & bus.MemWrite;

    assign rx_pop   = rd_strobe & (ofs == RXDATA_OFS) & ~rx_empty;
    assign tx_wr    = wr_strobe & (ofs == TXDATA_OFS);
    assign ctrl_wr  = wr_strobe & (ofs == CTRL_OFS);
    assign rx_flush = ctrl_wr & bus.WriteData[CTRL_FLUSH];
    assign clr_ovr  = ctrl_wr & bus.WriteData[CTRL_CLR_OVR];

    assign bus.in_ready = rx_en_q & ~rx_full;
    assign rx_push      = bus.in_valid & bus.in_ready;

    io_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_rx_fifo (
        .clk    (clk),
        .resetE (resetE),
        .push   (rx_push),
        .pop    (rx_pop),
        .flush  (rx_flush),
        .wdata  (bus.in_data),
        .head   (rx_head),
        .count  (rx_count),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    always_comb begin
        status                          = '0;
        status[ST_NONEMPTY]             = ~rx_empty;
        status[ST_FULL]                 = rx_full;
        status[ST_COUNT_LO +: 3]        = sat3(32'(rx_count));
        status[ST_TX_BUSY]              = (tx_state_q == TX_SEND);
        status[ST_RX_EN]                = rx_en_q;
        status[ST_TX_OVR]               = tx_ovr_q;
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (ofs)
                RXDATA_OFS: if (!rx_empty) rd_data[WIDTH-1:0] = rx_head;
                TXDATA_OFS: rd_data[WIDTH-1:0] = out_data_q;
                STATUS_OFS: rd_data = status;
                CTRL_OFS:   rd_data[CTRL_RX_EN] = rx_en_q;
                default:    rd_data = '0;
            endcase
        end
    end

    assign bus.Sel       = sel;
    assign bus.RdData    = rd_data;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (tx_state_q == TX_SEND);

    // TX sequencing; a write while a byte is pending and unacked is an overrun.
    always_comb begin
        tx_state_d = tx_state_q;
        out_data_d = out_data_q;
        tx_ovr_d   = tx_ovr_q;
        if (clr_ovr) tx_ovr_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_state_d = TX_SEND;
                    out_data_d = bus.WriteData[WIDTH-1:0];
                end
            end
            TX_SEND: begin
                if (bus.out_ack) begin
                    if (tx_wr) out_data_d = bus.WriteData[WIDTH-1:0];
                    else       tx_state_d = TX_IDLE;
                end else if (tx_wr) begin
                    tx_ovr_d = 1'b1;  // set wins over a same-cycle clear
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign rx_en_d = ctrl_wr ? bus.WriteData[CTRL_RX_EN] : rx_en_q;

    always_ff @(posedge clk) begin
        if (!resetE) begin
            tx_state_q <= TX_IDLE;
            out_data_q <= '0;
            tx_ovr_q   <= 1'b0;
            rx_en_q    <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            out_data_q <= out_data_d;
            tx_ovr_q   <= tx_ovr_d;
            rx_en_q    <= rx_en_d;
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed self-checking bench for io_port_ctrl.
module tb_io_port_ctrl;
    localparam logic [31:0] BASE = 32'h800;
    localparam logic [31:0] RXD  = BASE + 32'd0;
    localparam logic [31:0] TXD  = BASE + 32'd4;
    localparam logic [31:0] STA  = BASE + 32'd8;
    localparam logic [31:0] CTL  = BASE + 32'd12;

    logic clk = 1'b0;
    logic resetE;
    int   total = 0;
    int   bad   = 0;

    io_port_ctrl_if #(.WIDTH(8)) bus ();

    io_port_ctrl #(
        .BASE  (BASE),
        .DEPTH (4),
        .WIDTH (8)
    ) dut (
        .clk    (clk),
        .resetE (resetE),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load cycle: check combinational RdData, then let the edge apply side effects.
    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        bus.Adr      = a;
        bus.MemtoReg = 1'b1;
        #1;
        check(tag, bus.RdData, exp);
        tick();
        bus.MemtoReg = 1'b0;
        bus.Adr      = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Adr       = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        tick();
        bus.MemWrite  = 1'b0;
        bus.Adr       = '0;
        bus.WriteData = '0;
    endtask

    initial begin
        resetE        = 1'b0;
        bus.Adr       = '0;
        bus.WriteData = '0;
        bus.MemWrite  = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetE = 1'b1;
        tick();

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        rd(STA, "rst_status", 32'h40);
        rd(CTL, "rst_ctrl", 32'h4);

        // Two pushes then drain
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA1;
        tick();
        bus.in_data  = 8'hB2;
        tick();
        bus.in_valid = 1'b0;
        rd(STA, "st_two", 32'h49);
        rd(RXD, "rx_a1", 32'hA1);
        rd(RXD, "rx_b2", 32'hB2);
        rd(RXD, "rx_empty", 32'h0);
        rd(STA, "st_drained", 32'h40);

        // Push and read in the same cycle on an empty FIFO: read 0, no pop
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        rd(RXD, "rx_push_empty_rd", 32'h0);
        bus.in_valid = 1'b0;
        rd(STA, "st_one", 32'h45);
        rd(RXD, "rx_77", 32'h77);

        // Fill, then pop while the source holds a byte
        bus.in_valid = 1'b1;
        bus.in_data = 8'h11; tick();
        bus.in_data = 8'h22; tick();
        bus.in_data = 8'h33; tick();
        bus.in_data = 8'h44; tick();
        bus.in_data = 8'h55;
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        rd(STA, "st_full", 32'h53);
        rd(RXD, "rx_11_full", 32'h11);
        check("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        rd(STA, "st_refull", 32'h53);
        rd(RXD, "rx_22", 32'h22);
        rd(RXD, "rx_33", 32'h33);
        rd(RXD, "rx_44", 32'h44);
        rd(RXD, "rx_55_wrap", 32'h55);

        // TX path
        wr(TXD, 32'h3C);
        check("tx_valid", 32'(bus.out_valid), 32'd1);
        check("tx_data_3c", 32'(bus.out_data), 32'h3C);
        rd(TXD, "tx_readback", 32'h3C);
        wr(TXD, 32'hAA);
        check("tx_ovr_hold", 32'(bus.out_data), 32'h3C);
        rd(STA, "st_ovr", 32'hE0);
        bus.out_ack = 1'b1;
        wr(TXD, 32'h7E);
        bus.out_ack = 1'b0;
        check("tx_b2b_data", 32'(bus.out_data), 32'h7E);
        check("tx_b2b_valid", 32'(bus.out_valid), 32'd1);
        wr(CTL, 32'h2);
        rd(STA, "st_clr_ovr", 32'h20);
        check("rx_dis_in_ready", 32'(bus.in_ready), 32'd0);
        wr(CTL, 32'h4);
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        check("tx_done_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        check("idle_ack_ignored", 32'(bus.out_valid), 32'd0);

        // Flush beats a same-cycle push
        bus.in_valid = 1'b1;
        bus.in_data = 8'hC1; tick();
        bus.in_data = 8'hC2; tick();
        bus.in_data = 8'h99;
        wr(CTL, 32'h5);
        bus.in_valid = 1'b0;
        rd(STA, "st_flush", 32'h40);
        rd(RXD, "rx_flushed", 32'h0);

        // Outside the window
        bus.Adr      = BASE + 32'd16;
        bus.MemtoReg = 1'b1;
        #1;
        check("oow_sel_hi", 32'(bus.Sel), 32'd0);
        check("oow_rd_hi", bus.RdData, 32'h0);
        bus.Adr = BASE - 32'd4;
        #1;
        check("oow_sel_lo", 32'(bus.Sel), 32'd0);
        bus.Adr = BASE + 32'd4;
        #1;
        check("in_sel", 32'(bus.Sel), 32'd1);
        bus.MemtoReg = 1'b0;
        wr(BASE + 32'd20, 32'h12);
        check("oow_no_tx", 32'(bus.out_valid), 32'd0);
        wr(BASE + 32'd28, 32'h0);
        check("oow_no_ctrl", 32'(bus.in_ready), 32'd1);

        // Reset mid-transfer with FIFO contents
        wr(TXD, 32'h5A);
        bus.in_valid = 1'b1;
        bus.in_data = 8'hD1; tick();
        bus.in_data = 8'hD2; tick();
        bus.in_data = 8'hD3; tick();
        bus.in_valid = 1'b0;
        rd(STA, "st_pre_rst", 32'h6D);
        resetE = 1'b0;
        tick();
        resetE = 1'b1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        rd(STA, "st_post_rst", 32'h40);
        wr(CTL, 32'h0);
        check("rx_off_empty", 32'(bus.in_ready), 32'd0);
        rd(STA, "st_rx_off", 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
